// File: rtl/seg7_scan_decoder.sv
// Recovers per-digit hex values from a scanned 7-segment bus; SEG7_ACTIVE_LOW_EN inverts seg at the input register.
// Latency: pattern at pins before edge N commits on edge N+STABLE_CYC; observe-only, no backpressure.
module seg7_scan_decoder #(
  parameter int DIGITS     = 4,
  parameter int STABLE_CYC = 4
) (
  input  logic                                            clk,
  input  logic                                            rst,
  input  logic [6:0]                                      seg,
  input  logic [DIGITS-1:0]                               dig_sel,
  output logic [4*DIGITS-1:0]                             bin_out,
  output logic [DIGITS-1:0]                               valid,
  output logic                                            upd_stb,
  output logic [((DIGITS > 1) ? $clog2(DIGITS) : 1)-1:0]  upd_idx,
  output logic                                            err_stb
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CW = (STABLE_CYC > 1) ? $clog2(STABLE_CYC + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYC - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(STABLE_CYC);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {IDLE, TRACK, HOLD} state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [6:0]          s_seg, cand_seg_q, cand_seg_d;
  logic [DIGITS-1:0]   s_sel, cand_sel_q, cand_sel_d;
  logic                onehot, same, commit;
  logic                pat_known, pat_blank;
  logic [3:0]          pat_val;
  logic [IW-1:0]       sel_idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_seg <= '0;
      s_sel <= '0;
    end else begin
`ifdef SEG7_ACTIVE_LOW_EN
      s_seg <= ~seg;
`else
      s_seg <= seg;
`endif
      s_sel <= dig_sel;
    end
  end

  always_comb begin
    onehot = (s_sel != '0) && ((s_sel & (s_sel - DIGITS'(1))) == '0);
    same   = (s_sel == cand_sel_q) && (s_seg == cand_seg_q);
  end

  always_comb begin
    sel_idx = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (s_sel[i]) sel_idx = IW'(i);
    end
  end

  always_comb begin
    pat_known = 1'b1;
    pat_blank = 1'b0;
    pat_val   = 4'h0;
    case (s_seg)
      7'h7E: pat_val = 4'h0;
      7'h30: pat_val = 4'h1;
      7'h6D: pat_val = 4'h2;
      7'h79: pat_val = 4'h3;
      7'h33: pat_val = 4'h4;
      7'h5B: pat_val = 4'h5;
      7'h5F: pat_val = 4'h6;
      7'h70: pat_val = 4'h7;
      7'h7F: pat_val = 4'h8;
      7'h7B: pat_val = 4'h9;
      7'h77: pat_val = 4'hA;
      7'h1F: pat_val = 4'hB;
      7'h4E: pat_val = 4'hC;
      7'h3D: pat_val = 4'hD;
      7'h4F: pat_val = 4'hE;
      7'h47: pat_val = 4'hF;
      7'h00: begin
        pat_known = 1'b0;
        pat_blank = 1'b1;
      end
      default: pat_known = 1'b0;
    endcase
  end

  // Any fresh one-hot sample starts a new candidate; with STABLE_CYC==1 it commits at once.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cand_sel_d = cand_sel_q;
    cand_seg_d = cand_seg_q;
    commit     = 1'b0;
    case (state_q)
      IDLE: begin
        if (onehot) begin
          cand_sel_d = s_sel;
          cand_seg_d = s_seg;
          cnt_d      = CNT_ONE;
          state_d    = TRACK;
          if (STABLE_CYC == 1) begin
            commit  = 1'b1;
            state_d = HOLD;
          end
        end
      end
      TRACK: begin
        if (!onehot) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else if (!same) begin
          cand_sel_d = s_sel;
          cand_seg_d = s_seg;
          cnt_d      = CNT_ONE;
          if (STABLE_CYC == 1) begin
            commit  = 1'b1;
            state_d = HOLD;
          end
        end else if (cnt_q >= CNT_LAST) begin
          commit  = 1'b1;
          state_d = HOLD;
        end else begin
          cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        end
      end
      HOLD: begin
        if (!same) begin
          if (onehot) begin
            cand_sel_d = s_sel;
            cand_seg_d = s_seg;
            cnt_d      = CNT_ONE;
            state_d    = TRACK;
            if (STABLE_CYC == 1) begin
              commit  = 1'b1;
              state_d = HOLD;
            end
          end else begin
            cnt_d   = '0;
            state_d = IDLE;
          end
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      cand_sel_q <= '0;
      cand_seg_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cand_sel_q <= cand_sel_d;
      cand_seg_q <= cand_seg_d;
    end
  end

  // Only the strobed digit's nibble/valid bit may change on a commit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin_out <= '0;
      valid   <= '0;
      upd_stb <= 1'b0;
      upd_idx <= '0;
      err_stb <= 1'b0;
    end else begin
      upd_stb <= 1'b0;
      err_stb <= 1'b0;
      if (commit) begin
        for (int i = 0; i < DIGITS; i++) begin
          if (s_sel[i]) begin
            valid[i] <= pat_known;
            if (pat_known) bin_out[4*i +: 4] <= pat_val;
          end
        end
        if (pat_known || pat_blank) begin
          upd_stb <= 1'b1;
          upd_idx <= sel_idx;
        end else begin
          err_stb <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Scoreboard bench for seg7_scan_decoder: stimulus queues expected commits, a monitor checks each strobe.
module tb_seg7_scan_decoder;

  localparam int DIGITS     = 4;
  localparam int STABLE_CYC = 4;
  localparam int K_NONE  = 0;
  localparam int K_VAL   = 1;
  localparam int K_BLANK = 2;
  localparam int K_ERR   = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  seg;
  logic [3:0]  dig_sel;
  logic [15:0] bin_out;
  logic [3:0]  valid;
  logic        upd_stb;
  logic [1:0]  upd_idx;
  logic        err_stb;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    bit          err;
    int          idx;
    logic [15:0] bin;
    logic [3:0]  vld;
    int          edge_n;
  } exp_t;

  exp_t        q[$];
  logic [15:0] m_bin;
  logic [3:0]  m_vld;

  seg7_scan_decoder #(.DIGITS(DIGITS), .STABLE_CYC(STABLE_CYC)) dut (
    .clk     (clk),
    .rst     (rst),
    .seg     (seg),
    .dig_sel (dig_sel),
    .bin_out (bin_out),
    .valid   (valid),
    .upd_stb (upd_stb),
    .upd_idx (upd_idx),
    .err_stb (err_stb)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic exp_commit(input int kind, input int idx, input logic [3:0] v, input int edge_n);
    exp_t e;
    if (kind == K_VAL) begin
      m_bin[idx*4 +: 4] = v;
      m_vld[idx] = 1'b1;
    end else begin
      m_vld[idx] = 1'b0;
    end
    e.err    = (kind == K_ERR);
    e.idx    = idx;
    e.bin    = m_bin;
    e.vld    = m_vld;
    e.edge_n = edge_n;
    q.push_back(e);
  endtask

  // Apply inputs at a falling edge and hold them for n clock periods.
  task automatic drive(input logic [3:0] s, input logic [6:0] sg, input int n,
                       input int kind, input logic [3:0] v);
    int idx;
    @(negedge clk);
    dig_sel = s;
    seg     = sg;
    idx = 0;
    for (int i = 0; i < DIGITS; i++) if (s[i]) idx = i;
    if (kind != K_NONE) exp_commit(kind, idx, v, cyc + 1 + STABLE_CYC);
    repeat (n - 1) @(negedge clk);
  endtask

  always @(posedge clk) begin
    #1;
    if (upd_stb || err_stb) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_strobe edge=%0d upd=%0b err=%0b", cyc, upd_stb, err_stb);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("commit_edge", cyc, e.edge_n);
        check("strobe_kind", {upd_stb, err_stb}, e.err ? 2'b01 : 2'b10);
        if (!e.err) check("upd_idx", upd_idx, e.idx);
        check("bin_out", bin_out, e.bin);
        check("valid", valid, e.vld);
      end
    end
  end

  initial begin
    rst     = 1'b1;
    seg     = 7'h00;
    dig_sel = 4'b0000;
    m_bin   = '0;
    m_vld   = '0;
    repeat (3) @(negedge clk);
    check("rst_bin", bin_out, 16'h0);
    check("rst_valid", valid, 4'h0);
    check("rst_strobes", {upd_stb, err_stb, upd_idx}, 4'h0);

    // No strobe selected: segments alone must never commit.
    rst = 1'b0;
    seg = 7'h7F;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_outputs", {bin_out, valid, upd_stb, err_stb, upd_idx}, 24'h0);
    end

    drive(4'b0001, 7'h7E, 10, K_VAL, 4'h0);
    check("d0_valid", valid, 4'b0001);

    drive(4'b0001, 7'h30, 6, K_VAL, 4'h1);
    drive(4'b0010, 7'h6D, 6, K_VAL, 4'h2);
    drive(4'b0100, 7'h77, 6, K_VAL, 4'hA);
    drive(4'b1000, 7'h47, 6, K_VAL, 4'hF);
    check("scan_bin", bin_out, 16'hFA21);
    check("scan_valid", valid, 4'hF);

    drive(4'b0100, 7'h55, 6, K_ERR, 4'h0);
    check("err_valid", valid, 4'hB);
    check("err_bin", bin_out, 16'hFA21);
    drive(4'b0100, 7'h00, 6, K_BLANK, 4'h0);
    check("blank_valid", valid, 4'hB);

    drive(4'b0010, 7'h5B, 3, K_NONE, 4'h0);
    drive(4'b0010, 7'h5F, 6, K_VAL, 4'h6);
    drive(4'b0011, 7'h5F, 8, K_NONE, 4'h0);
    check("glitch_bin", bin_out, 16'hFA61);
    check("multihot_valid", valid, 4'hB);

    // Reset lands two samples into tracking digit 1; the count must restart.
    drive(4'b0010, 7'h33, 4, K_NONE, 4'h0);
    rst = 1'b1;
    #1;
    check("midrst_bin", bin_out, 16'h0);
    check("midrst_valid", valid, 4'h0);
    m_bin = '0;
    m_vld = '0;
    repeat (2) @(negedge clk);
    check("midrst_hold", {bin_out, valid, upd_stb, err_stb}, 22'h0);
    rst = 1'b0;
    exp_commit(K_VAL, 1, 4'h4, cyc + 1 + STABLE_CYC);
    repeat (10) @(negedge clk);
    check("post_rst_bin", bin_out, 16'h0040);
    check("post_rst_valid", valid, 4'b0010);

    repeat (3) @(negedge clk);
    check("queue_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
